// File: rtl/vecmat_pim_sched.sv
// Vector-matrix PIM row scheduler: issues rows to a fixed-latency PIM macro
// under credit control and buffers results in order for a ready/valid consumer.
//
// Ports:
//   clk, reset (sync, active-low)
//   cmd_valid/cmd_ready, cmd_base, cmd_len   : command (rows = cmd_len + 1)
//   pim_en, pim_addr, pim_data               : PIM macro side
//   res_valid/res_ready, res_data, res_addr,
//   res_last                                 : result stream
//   busy, done                               : status
module vecmat_pim_sched #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 18,
  parameter int PIM_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W-1:0] cmd_len,
  output logic [ADDR_W-1:0] pim_addr,
  output logic              pim_en,
  input  logic [DATA_W-1:0] pim_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [ADDR_W-1:0] res_addr,
  output logic              res_last,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C =
    (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] pim_addr_q, pim_addr_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;

  logic [PIM_LAT-1:0] tag_v_q, tag_v_d;
  logic [PIM_LAT-1:0] tag_last_q, tag_last_d;
  logic [ADDR_W-1:0]  tag_addr_q [PIM_LAT];
  logic [ADDR_W-1:0]  tag_addr_d [PIM_LAT];

  logic [DATA_W-1:0]     mem_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0]     mem_data_d [FIFO_DEPTH];
  logic [ADDR_W-1:0]     mem_addr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]     mem_addr_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last_q, mem_last_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic              credit_ok;
  logic              issue;
  logic [ADDR_W-1:0] issue_addr;
  logic              issue_last;
  logic              push;
  logic              nonempty;
  logic              pop;
  logic              head_last;

  // Rows in the PIM pipe plus rows buffered never exceed the buffer size,
  // so every PIM return always has a slot to land in.
  assign credit_ok  = ({1'b0, inflight_q} + {1'b0, count_q}) < DEPTH_C;
  assign issue      = (state_q == S_ISSUE) && credit_ok;
  assign issue_addr = base_q + row_q;
  assign issue_last = (row_q == len_q);
  assign push       = tag_v_q[PIM_LAT-1];
  assign nonempty   = (count_q != '0);
  assign pop        = nonempty && res_ready;
  assign head_last  = mem_last_q[rd_ptr_q];

  assign pim_en    = issue;
  assign pim_addr  = issue ? issue_addr : pim_addr_q;
  assign res_valid = nonempty;
  assign res_data  = nonempty ? mem_data_q[rd_ptr_q] : '0;
  assign res_addr  = nonempty ? mem_addr_q[rd_ptr_q] : '0;
  assign res_last  = nonempty && head_last;
  assign cmd_ready = (state_q == S_IDLE) && reset;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    row_d      = row_q;
    pim_addr_d = pim_addr_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          base_d  = cmd_base;
          len_d   = cmd_len;
          row_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue) begin
          row_d      = row_q + ADDR_W'(1);
          pim_addr_d = issue_addr;
          if (issue_last) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pop && head_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Tag pipe mirrors the PIM latency so each return is tagged with its row.
  always_comb begin
    tag_v_d    = tag_v_q;
    tag_last_d = tag_last_q;
    tag_addr_d = tag_addr_q;

    tag_v_d[0]    = issue;
    tag_last_d[0] = issue_last;
    tag_addr_d[0] = issue_addr;
    for (int i = 1; i < PIM_LAT; i++) begin
      tag_v_d[i]    = tag_v_q[i-1];
      tag_last_d[i] = tag_last_q[i-1];
      tag_addr_d[i] = tag_addr_q[i-1];
    end

    inflight_d = inflight_q
               + CNT_W'(issue)
               - CNT_W'(push);
  end

  always_comb begin
    mem_data_d = mem_data_q;
    mem_addr_d = mem_addr_q;
    mem_last_d = mem_last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (push) begin
      mem_data_d[wr_ptr_q] = pim_data;
      mem_addr_d[wr_ptr_q] = tag_addr_q[PIM_LAT-1];
      mem_last_d[wr_ptr_q] = tag_last_q[PIM_LAT-1];
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    count_d = count_q
            + CNT_W'(push)
            - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      row_q      <= '0;
      pim_addr_q <= '0;
      inflight_q <= '0;
      tag_v_q    <= '0;
      tag_last_q <= '0;
      tag_addr_q <= '{default: '0};
      mem_data_q <= '{default: '0};
      mem_addr_q <= '{default: '0};
      mem_last_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      row_q      <= row_d;
      pim_addr_q <= pim_addr_d;
      inflight_q <= inflight_d;
      tag_v_q    <= tag_v_d;
      tag_last_q <= tag_last_d;
      tag_addr_q <= tag_addr_d;
      mem_data_q <= mem_data_d;
      mem_addr_q <= mem_addr_d;
      mem_last_q <= mem_last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_vecmat_pim_sched.sv
// Directed bench for vecmat_pim_sched with a 2-cycle PIM model and
// an in-order result scoreboard.
module tb_vecmat_pim_sched;

  localparam logic [17:0] JUNK = 18'h2aaaa;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_base;
  logic [4:0]  cmd_len;
  logic [4:0]  pim_addr;
  logic        pim_en;
  logic [17:0] pim_data;
  logic        res_valid;
  logic        res_ready;
  logic [17:0] res_data;
  logic [4:0]  res_addr;
  logic        res_last;
  logic        busy;
  logic        done;

  vecmat_pim_sched dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_base  (cmd_base),
    .cmd_len   (cmd_len),
    .pim_addr  (pim_addr),
    .pim_en    (pim_en),
    .pim_data  (pim_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_addr  (res_addr),
    .res_last  (res_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [17:0] d;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   iss_log[$];
  int   pop_log[$];

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int n_acc = 0;
  int n_pop = 0;
  int issued = 0;
  int run = 0;
  int maxrun = 0;
  int first_rv = -1;
  int last_pop_cyc = 0;
  bit rr_rand = 0;

  logic [4:0]  cur_base = '0;
  logic [4:0]  cur_len = '0;
  logic [12:0] ser = '0;
  logic        en_d1 = 1'b0;
  logic        en_d2 = 1'b0;
  logic [17:0] v_d1 = '0;
  logic [17:0] v_d2 = '0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    logic        v_en;
    logic [17:0] v_val;
    logic        rst_now;
    logic [4:0]  ea;
    exp_t        e;
    @(negedge clk);
    v_en    = pim_en;
    v_val   = {ser, pim_addr};
    rst_now = reset;
    if (reset === 1'b1) begin
      if (cmd_valid && cmd_ready) begin
        cur_base = cmd_base;
        cur_len  = cmd_len;
        issued   = 0;
        acc_cyc  = cyc;
        n_acc++;
        n_pop    = 0;
        run      = 0;
        maxrun   = 0;
        first_rv = -1;
        iss_log.delete();
        pop_log.delete();
      end
      if (pim_en === 1'b1) begin
        ea = cur_base + 5'(issued);
        chk("iss_addr", {27'd0, pim_addr}, {27'd0, ea});
        e.a = pim_addr;
        e.d = v_val;
        e.l = (issued == int'(cur_len));
        exp_q.push_back(e);
        iss_log.push_back(int'(pim_addr));
        issued++;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      if (res_valid === 1'b1 && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_res", {27'd0, res_addr}, 32'hffff_ffff);
        end else begin
          e = exp_q.pop_front();
          chk("res_data", {14'd0, res_data}, {14'd0, e.d});
          chk("res_addr", {27'd0, res_addr}, {27'd0, e.a});
          chk("res_last", {31'd0, res_last}, {31'd0, e.l});
        end
        pop_log.push_back(int'(res_addr));
        n_pop++;
        if (res_last) last_pop_cyc = cyc;
      end
    end
    if (v_en === 1'b1) ser++;
    @(posedge clk);
    #1;
    cyc++;
    en_d2 = en_d1;
    v_d2  = v_d1;
    en_d1 = (v_en === 1'b1);
    v_d1  = v_val;
    pim_data = en_d2 ? v_d2 : JUNK;
    if (rst_now !== 1'b1) exp_q.delete();
    if (first_rv < 0 && res_valid === 1'b1) first_rv = cyc;
    if (rr_rand) res_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic start_cmd(input logic [4:0] b,
                           input logic [4:0] l,
                           input bit hold);
    int a0;
    a0 = n_acc;
    cmd_base  = b;
    cmd_len   = l;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (n_acc != a0) break;
    end
    if (n_acc == a0) chk("accept_timeout", 0, 1);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int dc);
    dc = -1;
    for (int i = 0; i < lim; i++) begin
      if (done === 1'b1) begin
        dc = cyc;
        break;
      end
      tick();
    end
    if (dc < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_pim_en"},   {31'd0, pim_en},    0);
    chk({tag, "_pim_addr"}, {27'd0, pim_addr},  0);
    chk({tag, "_res_valid"},{31'd0, res_valid}, 0);
    chk({tag, "_res_data"}, {14'd0, res_data},  0);
    chk({tag, "_res_addr"}, {27'd0, res_addr},  0);
    chk({tag, "_res_last"}, {31'd0, res_last},  0);
    chk({tag, "_busy"},     {31'd0, busy},      0);
    chk({tag, "_done"},     {31'd0, done},      0);
  endtask

  initial begin
    int dc;
    int dc2;
    int a1;
    int c2_exp[4];
    c2_exp = '{30, 31, 0, 1};

    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_base  = '0;
    cmd_len   = '0;
    res_ready = 1'b0;
    pim_data  = JUNK;

    // Power-on reset.
    tick();
    tick();
    chk_reset_outs("por");
    reset = 1'b1;
    tick();
    chk("por_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("por_busy", {31'd0, busy}, 0);

    // Case 1: base 0, len 7, always ready.
    res_ready = 1'b1;
    start_cmd(5'd0, 5'd7, 0);
    wait_done(100, dc);
    chk("c1_run", maxrun, 8);
    chk("c1_npop", n_pop, 8);
    chk("c1_latency", first_rv - acc_cyc, 4);
    chk("c1_done_after_pop", dc - last_pop_cyc, 1);
    chk("c1_sb_empty", exp_q.size(), 0);
    chk("c1_last_addr", pop_log[7], 7);
    chk("c1_addr_hold", {27'd0, pim_addr}, 7);
    tick();
    chk("c1_done_pulse", {31'd0, done}, 0);
    chk("c1_idle_busy", {31'd0, busy}, 0);

    // Case 2: address wrap.
    start_cmd(5'd30, 5'd3, 0);
    wait_done(100, dc);
    chk("c2_niss", iss_log.size(), 4);
    chk("c2_npop", pop_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("c2_iss%0d", i), iss_log[i], c2_exp[i]);
      chk($sformatf("c2_pop%0d", i), pop_log[i], c2_exp[i]);
    end

    // Case 3: consumer stalled, credit limit, then resume.
    res_ready = 1'b0;
    start_cmd(5'd0, 5'd15, 0);
    for (int i = 0; i < 12; i++) tick();
    chk("c3_issued_stall", issued, 4);
    chk("c3_pim_en_stall", {31'd0, pim_en}, 0);
    chk("c3_addr_hold", {27'd0, pim_addr}, 3);
    chk("c3_res_valid", {31'd0, res_valid}, 1);
    chk("c3_res_addr0", {27'd0, res_addr}, 0);
    res_ready = 1'b1;
    wait_done(200, dc);
    chk("c3_issued", issued, 16);
    chk("c3_npop", n_pop, 16);
    chk("c3_sb_empty", exp_q.size(), 0);

    // Case 4: random consumer back-pressure, wrapping 32 rows.
    rr_rand = 1'b1;
    start_cmd(5'd5, 5'd31, 0);
    wait_done(800, dc);
    rr_rand   = 1'b0;
    res_ready = 1'b1;
    chk("c4_issued", issued, 32);
    chk("c4_npop", n_pop, 32);
    chk("c4_last_addr", pop_log[31], 4);
    chk("c4_sb_empty", exp_q.size(), 0);

    // Case 5: reset in the middle of a command.
    res_ready = 1'b0;
    start_cmd(5'd10, 5'd7, 0);
    for (int i = 0; i < 20 && issued < 3; i++) tick();
    chk("c5_issued", issued, 3);
    reset = 1'b0;
    tick();
    chk_reset_outs("c5_rst");
    reset = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("c5_no_stale", {31'd0, res_valid}, 0);
    chk("c5_idle", {31'd0, busy}, 0);
    chk("c5_cmd_ready", {31'd0, cmd_ready}, 1);
    start_cmd(5'd3, 5'd1, 0);
    wait_done(100, dc);
    chk("c5_npop", n_pop, 2);
    chk("c5_pop0", pop_log[0], 3);
    chk("c5_pop1", pop_log[1], 4);
    chk("c5_sb_empty", exp_q.size(), 0);

    // Case 6: cmd_valid held through a whole command.
    start_cmd(5'd0, 5'd1, 1);
    wait_done(100, dc);
    chk("c6_ready_in_done", {31'd0, cmd_ready}, 0);
    a1 = n_acc;
    tick();
    chk("c6_idle_busy", {31'd0, busy}, 0);
    chk("c6_idle_ready", {31'd0, cmd_ready}, 1);
    chk("c6_done_low", {31'd0, done}, 0);
    tick();
    chk("c6_accepted", n_acc, a1 + 1);
    chk("c6_acc_cycle", acc_cyc, dc + 1);
    chk("c6_busy_again", {31'd0, busy}, 1);
    cmd_valid = 1'b0;
    wait_done(100, dc2);
    chk("c6_npop", n_pop, 2);
    chk("c6_sb_empty", exp_q.size(), 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/vecmat_pim_sched.md
VECMAT_PIM_SCHED -- requirements
Module: vecmat_pim_sched

Interface
REQ-001 Parameter ADDR_W, default 5, sets the width of the PIM row address.
REQ-002 Parameter DATA_W, default 18, sets the width of the PIM result.
REQ-003 Parameter PIM_LAT, default 2, is the cycles from pim_en to a valid pim_data; legal range 1..4.
REQ-004 Parameter FIFO_DEPTH, default 4, is the number of result buffer entries; SHALL be a power of 2 and at least 2.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  synchronous reset, active-low.
REQ-007 cmd_valid  input  1  command offered.
REQ-008 cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-009 cmd_base  input  ADDR_W  first PIM row address.
REQ-010 cmd_len  input  ADDR_W  number of rows minus 1.
REQ-011 pim_addr  output  ADDR_W  row address to the PIM macro.
REQ-012 pim_en  output  1  compute strobe to the PIM macro, one row per high cycle.
REQ-013 pim_data  input  DATA_W  PIM result, valid PIM_LAT cycles after pim_en.
REQ-014 res_valid  output  1  result available.
REQ-015 res_ready  input  1  consumer accepts the result.
REQ-016 res_data  output  DATA_W  result value.
REQ-017 res_addr  output  ADDR_W  row address that produced res_data.
REQ-018 res_last  output  1  final row of the command.
REQ-019 busy  output  1  high in any state other than IDLE.
REQ-020 done  output  1  one-cycle pulse when the command completes.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, DRAIN and DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-022 IDLE: cmd_valid=1 SHALL latch base/len, set the row counter to 0 and go to ISSUE on the next cycle.
REQ-023 ISSUE: pim_en SHALL be 1 exactly when inflight + fifo_count < FIFO_DEPTH (credit check), using registered counts.
REQ-024 pim_addr SHALL equal (base + row) mod 2^ADDR_W; wrap past 31 is legal (base=30, len=3 gives rows 30, 31, 0, 1).
REQ-025 The row counter SHALL increment only on cycles with pim_en=1; issuing row==len SHALL move the FSM to DRAIN.
REQ-026 pim_addr SHALL hold its last value when pim_en=0; pim_en SHALL be 0 outside ISSUE.
REQ-027 A PIM_LAT-deep tag pipeline (valid, addr, last) SHALL track each issue; at its output pim_data SHALL be pushed into the FIFO with its tags.
REQ-028 res_valid SHALL equal FIFO non-empty; res_data/res_addr/res_last SHALL come from the FIFO head; pop on res_valid&&res_ready.
REQ-029 Push and pop in the same cycle SHALL keep the count unchanged; the credit check SHALL guarantee the FIFO never overflows.
REQ-030 DRAIN SHALL go to DONE in the cycle after the res_last entry pops.
REQ-031 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-032 A new command SHALL be accepted no sooner than the cycle after DONE.
REQ-033 Results SHALL leave in issue order, with no loss or duplication under any res_ready pattern.
REQ-034 Minimum latency from cmd accept to first res_valid SHALL be 1 + PIM_LAT + 1 cycles (issue, PIM, FIFO write).
REQ-035 len=0 SHALL issue exactly one row, with res_last=1 on that row.

Reset
REQ-036 With reset=0 at a clock edge, the following SHALL be set on that edge: FSM to IDLE, FIFO and tag pipeline emptied, counters 0.
REQ-037 Output values in reset: cmd_ready=1 after release, pim_en=0, pim_addr=0, res_valid=0, res_data=0, res_addr=0, res_last=0, busy=0, done=0.
REQ-038 Reset mid-command SHALL discard all in-flight and buffered results; PIM returns arriving after reset SHALL be ignored.

Verification
REQ-039 Case 1: base=0, len=7, res_ready=1 -> pim_en high for 8 consecutive cycles, addr 0..7; 8 results in order; res_last on addr 7; done one cycle after the last pop.
REQ-040 Case 2: base=30, len=3 -> pim_addr sequence 30, 31, 0, 1; res_addr matches that sequence.
REQ-041 Case 3: len=15, res_ready=0 -> exactly FIFO_DEPTH (4) issues and then pim_en stays 0; raising res_ready resumes issue; 16 results total, none lost.
REQ-042 Case 4: random res_ready at 50% duty with a scoreboard keyed on pim_addr -> res_data for each row equals the pim_data driven PIM_LAT cycles after that row's pim_en.
REQ-043 Case 5: reset=0 asserted after 3 of 8 rows are issued -> the next cycle shows all outputs at reset values; the next command runs cleanly with no stale results.
REQ-044 Case 6: cmd_valid held high through a whole command -> the second command is accepted only in the IDLE cycle after done; busy stays 0 for exactly that one cycle.
